mac_share_arbiter: RTL and testbench

- Shares one pipelined multiply-add unit (result = A*B + C) among NREQ requesters; the unit is instantiated inside this block.
- Round-robin arbitration with a one-cycle grant handshake.
- Each accepted operation is tagged with its requester id; the result returns with that tag after a fixed latency.
- Sits between several producer blocks and the shared arithmetic resource, sustaining one operation per cycle.

---
 rtl/mac_share_arbiter.sv | 106 ++++++++++
 tb/tb_mac_share_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: round-robin sharing of one pipelined A*B+C unit among NREQ requesters
module mac_share_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 17
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ*WIDTH_IN-1:0]       a_in,
  input  logic [NREQ*WIDTH_IN-1:0]       b_in,
  input  logic [NREQ*WIDTH_IN-1:0]       c_in,
  output logic [NREQ-1:0]                gnt,
  output logic                           res_vld,
  output logic [(NREQ>1?$clog2(NREQ):1)-1:0] res_id,
  output logic [WIDTH_OUT-1:0]           res_data,
  output logic                           busy
);
  localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int PW  = 2 * WIDTH_IN;

  logic [NREQ-1:0]     elig;
  logic                found;
  logic [IDW-1:0]      win;
  logic [NREQ-1:0]     gnt_d, gnt_q;
  logic [IDW-1:0]      ptr_d, ptr_q;
  logic                vld0_d, vld0_q, vld1_d, vld1_q, vld2_d, vld2_q;
  logic [WIDTH_IN-1:0] a0_d, a0_q, b0_d, b0_q, c0_d, c0_q, c1_d, c1_q;
  logic [IDW-1:0]      id0_d, id0_q, id1_d, id1_q, id2_d, id2_q;
  logic [PW-1:0]       prod1_d, prod1_q;
  logic [WIDTH_OUT-1:0] data2_d, data2_q;

  // Round-robin pick from the pointer upward, masking the requester granted this cycle
  always_comb begin
    elig  = en ? (req & ~gnt_q) : '0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && elig[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
    gnt_d = '0;
    if (found) gnt_d[win] = 1'b1;
    ptr_d  = !found ? ptr_q : (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
    vld0_d = found;
    a0_d   = found ? a_in[int'(win)*WIDTH_IN +: WIDTH_IN] : a0_q;
    b0_d   = found ? b_in[int'(win)*WIDTH_IN +: WIDTH_IN] : b0_q;
    c0_d   = found ? c_in[int'(win)*WIDTH_IN +: WIDTH_IN] : c0_q;
    id0_d  = found ? win : id0_q;
  end

  // Multiply stage then add stage, both unsigned and zero-extended so nothing wraps
  always_comb begin
    vld1_d  = vld0_q;
    prod1_d = {{WIDTH_IN{1'b0}}, a0_q} * {{WIDTH_IN{1'b0}}, b0_q};
    c1_d    = c0_q;
    id1_d   = id0_q;
    vld2_d  = vld1_q;
    data2_d = {{(WIDTH_OUT-PW){1'b0}}, prod1_q} + {{(WIDTH_OUT-WIDTH_IN){1'b0}}, c1_q};
    id2_d   = id1_q;
  end

  // State registers; async reset drops everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      ptr_q   <= '0;
      vld0_q  <= 1'b0;
      a0_q    <= '0;
      b0_q    <= '0;
      c0_q    <= '0;
      id0_q   <= '0;
      vld1_q  <= 1'b0;
      prod1_q <= '0;
      c1_q    <= '0;
      id1_q   <= '0;
      vld2_q  <= 1'b0;
      data2_q <= '0;
      id2_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      vld0_q  <= vld0_d;
      a0_q    <= a0_d;
      b0_q    <= b0_d;
      c0_q    <= c0_d;
      id0_q   <= id0_d;
      vld1_q  <= vld1_d;
      prod1_q <= prod1_d;
      c1_q    <= c1_d;
      id1_q   <= id1_d;
      vld2_q  <= vld2_d;
      data2_q <= data2_d;
      id2_q   <= id2_d;
    end
  end

  assign gnt      = gnt_q;
  assign res_vld  = vld2_q;
  assign res_id   = id2_q;
  assign res_data = data2_q;
  assign busy     = vld0_q | vld1_q | vld2_q;
endmodule

// File: tb/tb_mac_share_arbiter.sv
// tb_mac_share_arbiter: directed checks of grant order, latency, en and async reset
module tb_mac_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] a_in = '0, b_in = '0, c_in = '0;
  logic [3:0]  gnt;
  logic        res_vld;
  logic [1:0]  res_id;
  logic [16:0] res_data;
  logic        busy;
  int          checks = 0, failures = 0;

  mac_share_arbiter #(.NREQ(4), .WIDTH_IN(8), .WIDTH_OUT(17)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .gnt(gnt), .res_vld(res_vld), .res_id(res_id), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic std_ops();
    for (int i = 0; i < 4; i++) begin
      a_in[i*8 +: 8] = 8'(i + 1);
      b_in[i*8 +: 8] = 8'd2;
      c_in[i*8 +: 8] = 8'(i);
    end
  endtask

  initial begin
    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_vld", res_vld, 0);
    chk("rst_id", res_id, 0);
    chk("rst_data", res_data, 0);
    chk("rst_busy", busy, 0);
    en = 1'b1;
    // single op on requester 2
    a_in[16 +: 8] = 8'd3; b_in[16 +: 8] = 8'd5; c_in[16 +: 8] = 8'd7;
    req = 4'b0100;
    tick();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_busy0", busy, 1);
    req = '0;
    tick();
    chk("single_gnt_off", gnt, 0);
    chk("single_vld_early", res_vld, 0);
    chk("single_busy1", busy, 1);
    tick();
    chk("single_vld", res_vld, 1);
    chk("single_id", res_id, 2);
    chk("single_data", res_data, 22);
    chk("single_busy2", busy, 1);
    tick();
    chk("single_vld_once", res_vld, 0);
    chk("single_busy_end", busy, 0);
    // full contention from pointer 0
    do_reset();
    en = 1'b1;
    std_ops();
    req = 4'b1111;
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk($sformatf("rr_gnt%0d", t), gnt, (t <= 8) ? (32'd1 << ((t - 1) % 4)) : 32'd0);
      chk($sformatf("rr_vld%0d", t), res_vld, (t >= 3) ? 1 : 0);
      if (t >= 3) begin
        chk($sformatf("rr_id%0d", t), res_id, (t - 3) % 4);
        chk($sformatf("rr_data%0d", t), res_data, 3 * ((t - 3) % 4) + 2);
      end
      if (t == 8) req = '0;
    end
    // alternating 1,3 with masking
    req = 4'b1010;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("mask_gnt%0d", t), gnt, (t % 2 == 0) ? 4'b0010 : 4'b1000);
    end
    req = '0;
    repeat (3) tick();
    chk("mask_idle", busy, 0);
    // max operands on requester 0
    a_in[7:0] = 8'hff; b_in[7:0] = 8'hff; c_in[7:0] = 8'hff;
    req = 4'b0001;
    tick();
    chk("max_gnt", gnt, 1);
    req = '0;
    tick();
    tick();
    chk("max_vld", res_vld, 1);
    chk("max_data", res_data, 65280);
    // zero operands, pointer wraps from 1 back to 0
    a_in[7:0] = 8'h0; b_in[7:0] = 8'h0; c_in[7:0] = 8'h0;
    req = 4'b0001;
    tick();
    chk("zero_gnt", gnt, 1);
    req = '0;
    tick();
    tick();
    chk("zero_vld", res_vld, 1);
    chk("zero_id", res_id, 0);
    chk("zero_data", res_data, 0);
    tick();
    // en drop with pointer at 1
    std_ops();
    req = 4'b1111;
    tick();
    chk("en_gnt", gnt, 4'b0010);
    en = 1'b0;
    tick();
    chk("en_nogrant0", gnt, 0);
    chk("en_busy", busy, 1);
    tick();
    chk("en_nogrant1", gnt, 0);
    chk("en_vld", res_vld, 1);
    chk("en_id", res_id, 1);
    chk("en_data", res_data, 5);
    tick();
    chk("en_nogrant2", gnt, 0);
    chk("en_busy_low", busy, 0);
    en = 1'b1;
    tick();
    chk("en_resume", gnt, 4'b0100);
    req = '0;
    repeat (3) tick();
    // async reset between grant and result
    req = 4'b0100;
    tick();
    chk("ar_gnt", gnt, 4'b0100);
    req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt0", gnt, 0);
    chk("ar_busy0", busy, 0);
    chk("ar_vld0", res_vld, 0);
    chk("ar_data0", res_data, 0);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk($sformatf("ar_novld%0d", t), res_vld, 0);
    end
    rst_n = 1'b1;
    req = 4'b1000;
    tick();
    chk("ar_first3", gnt, 4'b1000);
    req = 4'b1111;
    tick();
    chk("ar_ptr0", gnt, 4'b0001);
    tick();
    chk("ar_next1", gnt, 4'b0010);
    chk("ar_res_vld", res_vld, 1);
    chk("ar_res_id", res_id, 3);
    chk("ar_res_data", res_data, 11);
    req = '0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
